// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through byte queue between a bus write port
// and a UART transmitter. The head byte is presented combinationally and
// leaves on the tx_valid/tx_ready handshake. A write to a full queue is
// dropped and raises a sticky overflow flag.
//
// Handshake: a byte transfers to the transmitter on every rising edge where
// tx_valid and tx_ready are both high. Once tx_valid is high, tx_data stays
// stable until that transfer. tx_valid never depends on tx_ready.
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     tx_ready,
  output logic                     tx_valid,
  output logic [WIDTH-1:0]         tx_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;

  logic push;
  logic pop;
  logic ovf_set;

  // Status flags, handshake decode and the head byte as seen by the transmitter.
  always_comb begin
    empty    = (count_q == '0);
    full     = (count_q == CW'(DEPTH));
    tx_valid = en & ~empty;
    tx_data  = mem_q[rd_ptr_q];
    pop      = tx_valid & tx_ready;
    // A full queue still accepts a byte when the head leaves in the same cycle.
    push     = wr_en & (~full | pop);
    ovf_set  = wr_en & full & ~pop;
    count    = count_q;
    overflow = overflow_q;
  end

  // Next-state for storage, pointers, occupancy and the sticky overflow flag.
  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      mem_d[wr_ptr_q] = wr_data;
      // Pointers are exactly AW bits wide, so the increment wraps modulo DEPTH.
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A new drop outranks a clear that arrives in the same cycle.
    if (ovf_set) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end
  end

  // Control registers; reset discards queued bytes but leaves the array alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Byte storage; no reset, and nothing is written while reset is held.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: doc/uart_tx_fifo.md
UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 SHALL have parameter: DEPTH, 8, number of byte entries; power of two, 2..256.
REQ-002 SHALL have parameter: WIDTH, 8, data width in bits.
REQ-003 SHALL have port: clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: en  input  1  block enable; gates pops only.
REQ-006 SHALL have port: wr_en  input  1  bus write strobe (address 2'b00 decoded upstream with we).
REQ-007 SHALL have port: wr_data  input  WIDTH  byte to enqueue.
REQ-008 SHALL have port: tx_ready  input  1  transmitter idle, can accept a byte this cycle.
REQ-009 SHALL have port: tx_valid  output  1  tx_data holds a valid head byte.
REQ-010 SHALL have port: tx_data  output  WIDTH  head-of-queue byte to transmitter.
REQ-011 SHALL have port: full  output  1  count == DEPTH.
REQ-012 SHALL have port: empty  output  1  count == 0.
REQ-013 SHALL have port: count  output  $clog2(DEPTH)+1  current occupancy.
REQ-014 SHALL have port: overflow  output  1  sticky flag, write dropped while full.
REQ-015 SHALL have port: clr_ovf  input  1  clears overflow.

Function
REQ-016 SHALL store bytes in DEPTH x WIDTH register array with write pointer, read pointer, and occupancy counter, all registered.
REQ-017 SHALL use first-word-fall-through: tx_data = array[rd_ptr] combinationally; tx_valid = en & ~empty.
REQ-018 SHALL push on wr_en when ~full, or when full and a pop occurs in the same cycle.
REQ-019 SHALL pop on tx_valid & tx_ready (the handshake); rd_ptr advances on the following edge.
REQ-020 SHALL wrap pointers modulo DEPTH; no pointer width beyond $clog2(DEPTH) bits.
REQ-021 SHALL update count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
REQ-022 SHALL give write-to-valid latency of 1 cycle: byte written at edge N is on tx_data, with tx_valid high, after edge N when en=1.
REQ-023 SHALL NOT pop in the cycle a byte is written into an empty FIFO (tx_valid was 0 that cycle).
REQ-024 SHALL drop a write when full with no same-cycle pop: array, pointers, and count unchanged; overflow set on next edge.
REQ-025 SHALL hold overflow until clr_ovf=1; if a set condition and clr_ovf coincide, set wins.
REQ-026 SHALL, with en=0, force tx_valid=0 and block pops, while still accepting writes.
REQ-027 SHALL hold tx_data stable while tx_valid=1 and tx_ready=0.
REQ-028 SHALL ignore tx_ready while empty; count never underflows.

Reset
REQ-029 SHALL, when rst=1 at a rising edge, clear wr_ptr, rd_ptr, count, and overflow to 0; array contents need not be cleared.
REQ-030 SHALL output after reset: tx_valid=0, empty=1, full=0, count=0, overflow=0; tx_data undefined but not X-propagating into control.
REQ-031 SHALL let rst take priority over a simultaneous wr_en, pop, and clr_ovf; queued bytes are discarded.

Verification
REQ-032 SHALL verify single byte: en=1, tx_ready=0, write 0x41 -> next cycle tx_valid=1, tx_data=0x41, count=1; raise tx_ready one cycle -> empty=1, tx_valid=0.
REQ-033 SHALL verify order/wrap: DEPTH=8, write 0x00..0x07 -> full=1; pop 3; write 0x08..0x0A -> pops yield 0x03..0x0A in order, count returns to 0.
REQ-034 SHALL verify overflow: full FIFO, tx_ready=0, write 0xFF -> overflow=1, count=8, 0xFF never popped; clr_ovf -> overflow=0.
REQ-035 SHALL verify full plus simultaneous push/pop: full, tx_ready=1 and wr_en=1 with 0x55 -> count stays 8, overflow stays 0, 0x55 is the last byte popped.
REQ-036 SHALL verify enable gating: en=0, write 3 bytes with tx_ready=1 -> tx_valid=0, count=3; set en=1 -> 3 pops on consecutive cycles.
REQ-037 SHALL verify reset mid-operation: count=5, assert rst one cycle with wr_en=1 -> count=0, empty=1, overflow=0, tx_valid=0 on the next cycle.
